// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: word type, FSM state
// encoding and the word-alignment helper.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-cache handshake, later-stage controls and
// the IF/ID outputs presented to decode.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  en_d;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    word_t out_instr;
    word_t out_pc_plus_4;
    logic  out_valid;
    word_t pc;

    modport master (
        output imemREN, imemaddr, out_instr, out_pc_plus_4, out_valid, pc,
        input  ihit, imemload, en_d, redirect, redirect_pc, halt
    );

    modport slave (
        input  imemREN, imemaddr, out_instr, out_pc_plus_4, out_valid, pc,
        output ihit, imemload, en_d, redirect, redirect_pc, halt
    );

endinterface

// File: rtl/fetch_stage_latch.sv
// IF/ID pipeline register. Flush has priority over load; a bubble is all
// zeros including the valid bit.
module fetch_latch
    import fetch_stage_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    input  logic  flush,
    input  word_t instr_in,
    input  word_t pc_plus_4_in,
    output word_t instr,
    output word_t pc_plus_4,
    output logic  valid
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr     <= '0;
            pc_plus_4 <= '0;
            valid     <= 1'b0;
        end else if (flush) begin
            instr     <= '0;
            pc_plus_4 <= '0;
            valid     <= 1'b0;
        end else if (en) begin
            instr     <= instr_in;
            pc_plus_4 <= pc_plus_4_in;
            valid     <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, icache request FSM, one-entry hold buffer for
// decode stalls, and redirect/halt handling around outstanding misses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input logic         CLK,
    input logic         nRST,
    fetch_stage_if.master fif
);

    fetch_state_t state_q;
    word_t        pc_q;
    word_t        buf_instr_q;
    word_t        buf_pc4_q;
    word_t        pend_pc_q;
    logic         halt_pend_q;

    word_t pc_plus_4;
    logic  lat_en;
    logic  lat_flush;
    word_t lat_instr;
    word_t lat_pc4;

    assign pc_plus_4 = pc_q + PC_STEP;

    // pc_q is never advanced while a miss is outstanding, so it doubles as
    // the latched request address in DISCARD.
    assign fif.imemREN  = (state_q == FETCH) || (state_q == DISCARD);
    assign fif.imemaddr = pc_q;
    assign fif.pc       = pc_q;

    always_comb begin
        lat_en    = 1'b0;
        lat_flush = 1'b0;
        lat_instr = fif.imemload;
        lat_pc4   = pc_plus_4;
        unique case (state_q)
            FETCH: begin
                if (fif.halt || fif.redirect) begin
                    lat_flush = 1'b1;
                end else if (fif.en_d) begin
                    lat_en    = fif.ihit;
                    lat_flush = !fif.ihit;
                end
            end
            HOLD: begin
                lat_instr = buf_instr_q;
                lat_pc4   = buf_pc4_q;
                if (fif.halt || fif.redirect) begin
                    lat_flush = 1'b1;
                end else begin
                    lat_en = fif.en_d;
                end
            end
            DISCARD, HALTED: lat_flush = 1'b1;
            default:         lat_flush = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= FETCH;
            pc_q        <= PC_INIT;
            buf_instr_q <= '0;
            buf_pc4_q   <= '0;
            pend_pc_q   <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (fif.halt) begin
                        if (fif.ihit) begin
                            state_q <= HALTED;
                        end else begin
                            halt_pend_q <= 1'b1;
                            state_q     <= DISCARD;
                        end
                    end else if (fif.redirect) begin
                        if (fif.ihit) begin
                            pc_q <= word_align(fif.redirect_pc);
                        end else begin
                            pend_pc_q <= word_align(fif.redirect_pc);
                            state_q   <= DISCARD;
                        end
                    end else if (fif.ihit) begin
                        if (fif.en_d) begin
                            pc_q <= pc_plus_4;
                        end else begin
                            buf_instr_q <= fif.imemload;
                            buf_pc4_q   <= pc_plus_4;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (fif.halt) begin
                        state_q <= HALTED;
                    end else if (fif.redirect) begin
                        pc_q    <= word_align(fif.redirect_pc);
                        state_q <= FETCH;
                    end else if (fif.en_d) begin
                        pc_q    <= pc_plus_4;
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (fif.ihit) begin
                        if (fif.halt || halt_pend_q) begin
                            state_q <= HALTED;
                        end else begin
                            // A redirect arriving with the hit is the youngest target.
                            pc_q    <= fif.redirect ? word_align(fif.redirect_pc) : pend_pc_q;
                            state_q <= FETCH;
                        end
                    end else if (fif.halt) begin
                        halt_pend_q <= 1'b1;
                    end else if (fif.redirect) begin
                        pend_pc_q <= word_align(fif.redirect_pc);
                    end
                end
                HALTED:  state_q <= HALTED;
                default: state_q <= HALTED;
            endcase
        end
    end

    fetch_latch u_latch (
        .CLK          (CLK),
        .nRST         (nRST),
        .en           (lat_en),
        .flush        (lat_flush),
        .instr_in     (lat_instr),
        .pc_plus_4_in (lat_pc4),
        .instr        (fif.out_instr),
        .pc_plus_4    (fif.out_pc_plus_4),
        .valid        (fif.out_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (PC_INIT 0 and 0xFFFFFFFC),
// expected IF/ID words queued at stimulus time and popped on delivery.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct {
        word_t instr;
        word_t pc4;
    } exp_t;

    logic CLK;
    logic nRST0;
    logic nRST1;
    int   checks;
    int   errors;
    exp_t sb[$];

    fetch_stage_if fi0 ();
    fetch_stage_if fi1 ();

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut0 (
        .CLK  (CLK),
        .nRST (nRST0),
        .fif  (fi0)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut1 (
        .CLK  (CLK),
        .nRST (nRST1),
        .fif  (fi1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input word_t instr, input word_t pc4,
                          input logic valid);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=delivery expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, instr, e.instr);
            chk({tag, "_pc4"}, pc4, e.pc4);
            chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        end
    endtask

    task automatic drive0(input logic ihit, input word_t load, input logic en_d,
                          input logic redir, input word_t rpc, input logic halt);
        fi0.ihit        = ihit;
        fi0.imemload    = load;
        fi0.en_d        = en_d;
        fi0.redirect    = redir;
        fi0.redirect_pc = rpc;
        fi0.halt        = halt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRST0  = 1'b1;
        nRST1  = 1'b1;
        drive0(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        fi1.ihit = 1'b0; fi1.imemload = '0; fi1.en_d = 1'b0;
        fi1.redirect = 1'b0; fi1.redirect_pc = '0; fi1.halt = 1'b0;
        #1;
        nRST0 = 1'b0;
        nRST1 = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_instr", fi0.out_instr, 32'h0);
        chk("rst_pc4", fi0.out_pc_plus_4, 32'h0);
        chk("rst_valid", {31'd0, fi0.out_valid}, 32'd0);
        chk("rst_pc", fi0.pc, 32'h0);
        chk("rst_ren", {31'd0, fi0.imemREN}, 32'd1);
        nRST0 = 1'b1;

        // 1: single-cycle hit delivery
        drive0(1'b1, 32'h2008_000A, 1'b1, 1'b0, '0, 1'b0);
        sb.push_back('{32'h2008_000A, 32'h4});
        tick();
        sb_chk("t1", fi0.out_instr, fi0.out_pc_plus_4, fi0.out_valid);
        chk("t1_addr", fi0.imemaddr, 32'h4);
        drive0(1'b1, 32'h2009_0001, 1'b1, 1'b0, '0, 1'b0);
        sb.push_back('{32'h2009_0001, 32'h8});
        tick();
        sb_chk("t1b", fi0.out_instr, fi0.out_pc_plus_4, fi0.out_valid);

        // 2: hit during a decode stall goes to the hold buffer
        drive0(1'b1, 32'h8C22_0000, 1'b0, 1'b0, '0, 1'b0);
        tick();
        drive0(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_ren", {31'd0, fi0.imemREN}, 32'd0);
            chk("t2_stall_instr", fi0.out_instr, 32'h2009_0001);
            chk("t2_stall_pc4", fi0.out_pc_plus_4, 32'h8);
            if (i < 2) tick();
        end
        drive0(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        sb.push_back('{32'h8C22_0000, 32'hC});
        tick();
        sb_chk("t2", fi0.out_instr, fi0.out_pc_plus_4, fi0.out_valid);
        chk("t2_addr", fi0.imemaddr, 32'hC);
        chk("t2_ren", {31'd0, fi0.imemREN}, 32'd1);
        drive0(1'b1, 32'h1111_1111, 1'b1, 1'b0, '0, 1'b0);
        sb.push_back('{32'h1111_1111, 32'h10});
        tick();
        sb_chk("t2b", fi0.out_instr, fi0.out_pc_plus_4, fi0.out_valid);

        // 3: redirect during a miss waits out the outstanding request
        drive0(1'b0, '0, 1'b1, 1'b1, 32'h43, 1'b0);
        tick();
        chk("t3_valid", {31'd0, fi0.out_valid}, 32'd0);
        chk("t3_addr_hold", fi0.imemaddr, 32'h10);
        drive0(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        chk("t3_addr_hold2", fi0.imemaddr, 32'h10);
        chk("t3_ren", {31'd0, fi0.imemREN}, 32'd1);
        drive0(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, 1'b0);
        tick();
        chk("t3_drop_valid", {31'd0, fi0.out_valid}, 32'd0);
        chk("t3_drop_instr", fi0.out_instr, 32'h0);
        chk("t3_target", fi0.imemaddr, 32'h40);

        // 4: redirect with a hit under stall flushes instead of holding
        drive0(1'b1, 32'h5555_0000, 1'b1, 1'b1, 32'h20, 1'b0);
        tick();
        chk("t4_pre_addr", fi0.imemaddr, 32'h20);
        drive0(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h40, 1'b0);
        tick();
        chk("t4_valid", {31'd0, fi0.out_valid}, 32'd0);
        chk("t4_ren", {31'd0, fi0.imemREN}, 32'd1);
        chk("t4_addr", fi0.imemaddr, 32'h40);

        // 5: halt during a miss, then permanent stop until reset
        drive0(1'b1, 32'h0, 1'b1, 1'b1, 32'h30, 1'b0);
        tick();
        drive0(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        tick();
        chk("t5_ren_miss", {31'd0, fi0.imemREN}, 32'd1);
        chk("t5_addr_miss", fi0.imemaddr, 32'h30);
        drive0(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        chk("t5_ren_miss2", {31'd0, fi0.imemREN}, 32'd1);
        drive0(1'b1, 32'hABCD_0000, 1'b1, 1'b0, '0, 1'b0);
        tick();
        chk("t5_ren_halted", {31'd0, fi0.imemREN}, 32'd0);
        chk("t5_valid", {31'd0, fi0.out_valid}, 32'd0);
        drive0(1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h100, 1'b0);
        tick();
        tick();
        chk("t5_redir_ign_ren", {31'd0, fi0.imemREN}, 32'd0);
        chk("t5_redir_ign_pc", fi0.pc, 32'h30);
        chk("t5_redir_ign_valid", {31'd0, fi0.out_valid}, 32'd0);
        drive0(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        nRST0 = 1'b0;
        #1;
        chk("t5_rst_addr", fi0.imemaddr, 32'h0);
        chk("t5_rst_ren", {31'd0, fi0.imemREN}, 32'd1);
        tick();
        nRST0 = 1'b1;

        // 6: PC wrap at the top of the address space, then async reset mid-miss
        nRST1 = 1'b1;
        chk("t6_init_addr", fi1.imemaddr, 32'hFFFF_FFFC);
        fi1.ihit = 1'b1; fi1.imemload = 32'hAAAA_5555; fi1.en_d = 1'b1;
        sb.push_back('{32'hAAAA_5555, 32'h0});
        tick();
        sb_chk("t6", fi1.out_instr, fi1.out_pc_plus_4, fi1.out_valid);
        chk("t6_addr", fi1.imemaddr, 32'h0);
        fi1.ihit = 1'b0; fi1.en_d = 1'b0;
        tick();
        chk("t6_miss_instr", fi1.out_instr, 32'hAAAA_5555);
        #3;
        nRST1 = 1'b0;
        #1;
        chk("t6_async_instr", fi1.out_instr, 32'h0);
        chk("t6_async_valid", {31'd0, fi1.out_valid}, 32'd0);
        chk("t6_async_addr", fi1.imemaddr, 32'hFFFF_FFFC);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
